// File: rtl/regfile_seq_if.sv
// regfile_seq_if: instruction handshake plus register-bank control bundle of regfile_sequencer.
interface regfile_seq_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] wb_data;
    logic [3:0]  cont;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        regwrite;
    logic        done;
    logic        illegal;
    modport master (
        input  instr_valid, instr, pc, wb_data,
        output instr_ready, cont, rr1, rr2, wr, wd, regwrite, done, illegal
    );
    modport slave (
        output instr_valid, instr, pc, wb_data,
        input  instr_ready, cont, rr1, rr2, wr, wd, regwrite, done, illegal
    );
endinterface

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: 10-phase register-file access sequencer for the multicycle MIPS datapath.
// REGFILE_SEQ_ZERO_GUARD_EN: when defined, writes to $zero never raise regwrite.
module regfile_sequencer (
    input  logic           clk,
    input  logic           rst,
    regfile_seq_if.master  bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state;
    logic [3:0]  cont;
    logic [4:0]  rr1, rr2, wr, dst_q, dec_dst;
    logic [31:0] wd, ewd_q, dec_ewd;
    logic        regwrite, done, illegal;
    logic        wen_q, early_q, ill_q, dec_w, dec_early, dec_ill, dst_ok;
    logic [5:0]  op;
    assign op = bus.instr[31:26];
    always_comb begin
        dec_w     = 1'b0;
        dec_early = 1'b0;
        dec_ill   = 1'b0;
        dec_dst   = bus.instr[20:16];
        dec_ewd   = {bus.instr[15:0], 16'h0000};
        case (op)
            6'h00: begin
                dec_w   = bus.instr[5:0] != 6'h08;
                dec_dst = bus.instr[15:11];
            end
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23: dec_w = 1'b1;
            6'h0F: begin
                dec_w     = 1'b1;
                dec_early = 1'b1;
            end
            6'h03: begin
                dec_w     = 1'b1;
                dec_early = 1'b1;
                dec_dst   = 5'd31;
                dec_ewd   = bus.pc + 32'd4;
            end
            6'h02, 6'h04, 6'h05, 6'h2B: dec_w = 1'b0;
            default: dec_ill = 1'b1;
        endcase
    end
`ifdef REGFILE_SEQ_ZERO_GUARD_EN
    assign dst_ok = dst_q != 5'd0;
`else
    assign dst_ok = 1'b1;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cont     <= 4'd0;
            rr1      <= 5'd0;
            rr2      <= 5'd0;
            wr       <= 5'd0;
            wd       <= 32'd0;
            regwrite <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            wen_q    <= 1'b0;
            early_q  <= 1'b0;
            ill_q    <= 1'b0;
            dst_q    <= 5'd0;
            ewd_q    <= 32'd0;
        end else if (state == IDLE) begin
            if (bus.instr_valid) begin
                state   <= RUN;
                cont    <= 4'd0;
                rr1     <= bus.instr[25:21];
                rr2     <= bus.instr[20:16];
                wen_q   <= dec_w;
                early_q <= dec_early;
                ill_q   <= dec_ill;
                dst_q   <= dec_dst;
                ewd_q   <= dec_ewd;
            end
        end else begin
            state    <= cont == 4'd9 ? IDLE : RUN;
            cont     <= cont == 4'd9 ? 4'd0 : cont + 4'd1;
            regwrite <= wen_q && dst_ok && (early_q ? cont == 4'd5 : cont == 4'd8);
            done     <= cont == 4'd8;
            illegal  <= cont == 4'd8 && ill_q;
            // wr/wd load even when the zero guard suppresses the strobe
            if (wen_q && early_q && cont == 4'd5) begin
                wr <= dst_q;
                wd <= ewd_q;
            end
            if (wen_q && !early_q && cont == 4'd8) begin
                wr <= dst_q;
                wd <= bus.wb_data;
            end
        end
    end
    assign bus.instr_ready = state == IDLE;
    assign bus.cont        = cont;
    assign bus.rr1         = rr1;
    assign bus.rr2         = rr2;
    assign bus.wr          = wr;
    assign bus.wd          = wd;
    assign bus.regwrite    = regwrite;
    assign bus.done        = done;
    assign bus.illegal     = illegal;
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: scoreboard bench; every regwrite/done/illegal cycle is matched against a queued expectation.
module tb_regfile_sequencer;
    typedef struct packed {
        logic [3:0]  c;
        logic        rw;
        logic        dn;
        logic        il;
        logic [4:0]  wr;
        logic [31:0] wd;
    } ev_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    regfile_seq_if bus();
    regfile_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int          vectors = 0;
    int          miscompares = 0;
    ev_t         exp_q[$];
    ev_t         obs, exp_e;
    logic [4:0]  last_wr = 5'd0;
    logic [31:0] last_wd = 32'd0;
    time         t_acc;
    logic [3:0]  first_cont;
    always @(negedge clk) begin
        if (!rst && (bus.regwrite || bus.done || bus.illegal)) begin
            obs = {bus.cont, bus.regwrite, bus.done, bus.illegal, bus.wr, bus.wd};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event got %h required none", obs);
            end else begin
                exp_e = exp_q.pop_front();
                if (obs !== exp_e) begin
                    miscompares++;
                    $display("FAIL event got cont/rw/done/ill/wr/wd=%h required %h", obs, exp_e);
                end
            end
        end
    end
    task automatic issue(input logic [31:0] i, input logic [31:0] p, input logic [31:0] d, input bit hold);
        bit w, early, ill, rwv;
        logic [4:0]  dst;
        logic [31:0] v;
        ev_t e;
        int n;
        w = 0; early = 0; ill = 0; dst = i[20:16]; v = d;
        case (i[31:26])
            6'h00: begin w = i[5:0] != 6'h08; dst = i[15:11]; end
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23: w = 1;
            6'h0F: begin w = 1; early = 1; v = {i[15:0], 16'h0000}; end
            6'h03: begin w = 1; early = 1; dst = 5'd31; v = p + 32'd4; end
            6'h02, 6'h04, 6'h05, 6'h2B: w = 0;
            default: ill = 1;
        endcase
`ifdef REGFILE_SEQ_ZERO_GUARD_EN
        rwv = w && dst != 5'd0;
`else
        rwv = w;
`endif
        if (w) begin last_wr = dst; last_wd = v; end
        if (early && rwv) begin
            e = {4'd6, 1'b1, 1'b0, 1'b0, dst, v};
            exp_q.push_back(e);
        end
        e = {4'd9, rwv && !early, 1'b1, ill, last_wr, last_wd};
        exp_q.push_back(e);
        instr_valid_drive(i, p);
        n = 0;
        while (!bus.instr_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.instr_ready) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout ready=%b required 1", bus.instr_ready);
        end
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        first_cont = bus.cont;
        if (!hold) begin
            bus.instr_valid = 1'b0;
            bus.instr = $urandom;
            bus.pc = $urandom;
        end
        n = 0;
        while (bus.cont != 4'd9 && n < 12) begin
            bus.wb_data = bus.cont == 4'd8 ? d : $urandom;
            @(negedge clk);
            n++;
        end
        if (bus.cont != 4'd9) begin
            vectors++; miscompares++;
            $display("FAIL run_timeout cont=%0d required 9", bus.cont);
        end
        bus.wb_data = $urandom;
        @(negedge clk);
    endtask
    task automatic instr_valid_drive(input logic [31:0] i, input logic [31:0] p);
        bus.instr_valid = 1'b1;
        bus.instr = i;
        bus.pc = p;
    endtask
    task automatic test_reset;
        bus.instr_valid = 1'b0; bus.instr = '0; bus.pc = '0; bus.wb_data = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.cont, bus.rr1, bus.rr2, bus.wr, bus.wd, bus.regwrite, bus.done, bus.illegal, bus.instr_ready}
            !== {4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_values got cont=%0d rr1=%0d rr2=%0d wr=%0d wd=%h rw=%b done=%b ill=%b rdy=%b required zeros rdy=1",
                     bus.cont, bus.rr1, bus.rr2, bus.wr, bus.wd, bus.regwrite, bus.done, bus.illegal, bus.instr_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask
    task automatic test_reset_mid_run;
        int n;
        issue(32'h0C00_0000, 32'h0000_1000, 32'h0, 0);
        instr_valid_drive(32'h8D28_0004, 32'h0000_2000);
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        n = 0;
        while (bus.cont != 4'd7 && n < 12) begin @(negedge clk); n++; end
        vectors++;
        if (bus.cont !== 4'd7) begin
            miscompares++;
            $display("FAIL mid_run_reach7 cont=%0d required 7", bus.cont);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.cont, bus.rr1, bus.rr2, bus.wr, bus.wd, bus.regwrite, bus.done, bus.illegal, bus.instr_ready}
            !== {4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL async_reset got cont=%0d rr1=%0d rr2=%0d wr=%0d wd=%h rw=%b done=%b ill=%b rdy=%b required zeros rdy=1",
                     bus.cont, bus.rr1, bus.rr2, bus.wr, bus.wd, bus.regwrite, bus.done, bus.illegal, bus.instr_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        last_wr = 5'd0;
        last_wd = 32'd0;
        repeat (3) @(negedge clk);
        issue(32'h2128_0005, 32'h0, 32'h0000_0055, 0);
        vectors++;
        if (first_cont !== 4'd0) begin
            miscompares++;
            $display("FAIL restart_cont got %0d required 0", first_cont);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL mid_run_pending got %0d required 0", exp_q.size());
        end
    endtask
    task automatic test_addi;
        issue(32'h2128_0005, 32'h0000_0040, 32'h0000_000C, 0);
        vectors++;
        if ({bus.rr1, bus.rr2, bus.wr, bus.wd} !== {5'd9, 5'd8, 5'd8, 32'h0000_000C}) begin
            miscompares++;
            $display("FAIL addi_fields got rr1=%0d rr2=%0d wr=%0d wd=%h required 9 8 8 0000000c",
                     bus.rr1, bus.rr2, bus.wr, bus.wd);
        end
        issue(32'h8D2B_0010, 32'h0000_0044, 32'hDEAD_BEEF, 0);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL addi_pending got %0d required 0", exp_q.size());
        end
    endtask
    task automatic test_lui;
        issue(32'h3C0A_1234, 32'h0000_0048, 32'hAAAA_5555, 0);
        vectors++;
        if ({bus.wr, bus.wd} !== {5'd10, 32'h1234_0000}) begin
            miscompares++;
            $display("FAIL lui_fields got wr=%0d wd=%h required 10 12340000", bus.wr, bus.wd);
        end
    endtask
    task automatic test_jal;
        issue(32'h0C00_0123, 32'hFFFF_FFFC, 32'h1357_9BDF, 0);
        vectors++;
        if ({bus.wr, bus.wd} !== {5'd31, 32'h0000_0000}) begin
            miscompares++;
            $display("FAIL jal_wrap got wr=%0d wd=%h required 31 00000000", bus.wr, bus.wd);
        end
    endtask
    task automatic test_back_to_back;
        time t_first;
        issue(32'hAD28_0008, 32'h0000_0100, 32'h1111_1111, 1);
        t_first = t_acc;
        issue(32'hFC00_0000, 32'h0000_0104, 32'h2222_2222, 1);
        bus.instr_valid = 1'b0;
        vectors++;
        if (t_acc - t_first != 110) begin
            miscompares++;
            $display("FAIL accept_spacing got %0t required 110", t_acc - t_first);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_pending got %0d required 0", exp_q.size());
        end
    endtask
    task automatic test_zero_dest;
        issue(32'h0000_0020, 32'h0000_0200, 32'h0BAD_F00D, 0);
        vectors++;
        if ({bus.wr, bus.wd} !== {5'd0, 32'h0BAD_F00D}) begin
            miscompares++;
            $display("FAIL zero_dest_load got wr=%0d wd=%h required 0 0badf00d", bus.wr, bus.wd);
        end
        issue(32'h03E0_0008, 32'h0000_0204, 32'h7777_7777, 0);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL zero_dest_pending got %0d required 0", exp_q.size());
        end
    endtask
    initial begin
        test_reset;
        test_reset_mid_run;
        test_addi;
        test_lui;
        test_jal;
        test_back_to_back;
        test_zero_dest;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
